// File: rtl/rda_wide_sequencer.sv
// Wide-operand adder controller: slices WIDTH-bit operands through an external 16-bit
// combinational adder core, chaining carries. Optional RDA_SEQ_OVF_EN adds result_ovf.
//
// state | meaning
// IDLE  | ready for a new operand pair
// RUN   | one 16-bit slice per cycle through the adder core
// DONE  | result presented, waiting for out_ready
module rda_wide_sequencer #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_cin,
   output logic [15:0]      add_a,
   output logic [15:0]      add_b,
   output logic             add_cin,
   input  logic [16:0]      add_sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
`ifdef RDA_SEQ_OVF_EN
   output logic             result_ovf,
`endif
   output logic             result_cout
);

   localparam int SLICES = WIDTH / 16;
   localparam int IDXW   = (SLICES > 1) ? $clog2(SLICES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nx;
   logic [WIDTH-1:0]  a_reg, b_reg, result_reg;
   logic [IDXW-1:0]   idx;
   logic              carry_reg;
   logic              last_slice;
   logic              accept;
   logic [15:0]       slice_a, slice_b;

   assign last_slice = (idx == IDXW'(SLICES - 1));
   assign accept     = in_valid && in_ready;

   // Slice mux written as a compare loop so idx never drives a variable part-select.
   always_comb begin
      slice_a = '0;
      slice_b = '0;
      for (int i = 0; i < SLICES; i++) begin
         if (idx == IDXW'(i)) begin
            slice_a = a_reg[i*16 +: 16];
            slice_b = b_reg[i*16 +: 16];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      add_a       = '0;
      add_b       = '0;
      add_cin     = 1'b0;
      result      = '0;
      result_cout = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = RUN;
         end
         RUN: begin
            add_a   = slice_a;
            add_b   = slice_b;
            add_cin = carry_reg;
            if (last_slice) state_nx = DONE;
         end
         DONE: begin
            out_valid   = 1'b1;
            result      = result_reg;
            result_cout = carry_reg;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg      <= '0;
         b_reg      <= '0;
         result_reg <= '0;
         idx        <= '0;
         carry_reg  <= 1'b0;
      end else if (accept) begin
         a_reg     <= op_a;
         b_reg     <= op_b;
         carry_reg <= op_cin;
         idx       <= '0;
      end else if (state == RUN) begin
         for (int i = 0; i < SLICES; i++) begin
            if (idx == IDXW'(i)) result_reg[i*16 +: 16] <= add_sum[15:0];
         end
         carry_reg <= add_sum[16];
         if (!last_slice) idx <= idx + IDXW'(1);
      end
   end

`ifdef RDA_SEQ_OVF_EN
   assign result_ovf = (state == DONE) &&
                       (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                       (result_reg[WIDTH-1] != a_reg[WIDTH-1]);
`endif

endmodule
